// File: rtl/right_shifter_n_bit.sv
// Registered N-bit logical right barrel shifter with carry-out.
// Result and last shifted-out bit appear one clock after sampling.
module right_shifter_n_bit #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] shift,
  output logic [N-1:0]  out,
  output logic          cout
);

  localparam logic [SW-1:0] NS = SW'(N);

  logic [N-1:0] dat [SW+1];
  logic         cy  [SW+1];
  logic         ovr;
  logic [N-1:0] res_d, res_q;
  logic         cy_d, cy_q;

  assign dat[0] = in_a;
  assign cy[0]  = 1'b0;

  // A guard bit below the LSB catches the last bit shifted out of the stage.
  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    logic [N:0] w;
    assign w          = {dat[k], 1'b0} >> AMT;
    assign dat[k + 1] = shift[k] ? w[N:1] : dat[k];
    assign cy[k + 1]  = shift[k] ? w[0]   : cy[k];
  end

  assign ovr = shift > NS;

  always_comb begin
    res_d = dat[SW];
    cy_d  = cy[SW];
    if (ovr) begin
      res_d = '0;
      cy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      cy_q  <= cy_d;
    end
  end

  assign out  = res_q;
  assign cout = cy_q;

endmodule

// File: tb/tb_right_shifter_n_bit.sv
// Bench for right_shifter_n_bit: directed checks at N=8 and a
// randomized sweep at N=8, 16 and 5 against an arithmetic model.
module tb_right_shifter_n_bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8,  o8;
  logic [3:0]  s8;
  logic        c8;
  logic [15:0] a16, o16;
  logic [4:0]  s16;
  logic        c16;
  logic [4:0]  a5,  o5;
  logic [3:0]  s5;
  logic        c5;

  int n_chk  = 0;
  int n_fail = 0;

  right_shifter_n_bit #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_a(a8),
    .shift(s8), .out(o8), .cout(c8)
  );
  right_shifter_n_bit #(.N(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_a(a16),
    .shift(s16), .out(o16), .cout(c16)
  );
  right_shifter_n_bit #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_a(a5),
    .shift(s5), .out(o5), .cout(c5)
  );

  function automatic int ref_out(input int n, input int a, input int s);
    if (s >= n) return 0;
    return a / (1 << s);
  endfunction

  function automatic int ref_c(input int n, input int a, input int s);
    if (s == 0 || s > n) return 0;
    return (a / (1 << (s - 1))) % 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input string tag, input logic [7:0] a,
                       input logic [3:0] s, input logic [7:0] eo,
                       input logic ec);
    a8 = a;
    s8 = s;
    tick();
    check({tag, "_out"}, 32'(o8), 32'(eo));
    check({tag, "_cout"}, 32'(c8), 32'(ec));
  endtask

  initial begin
    int e8o, e8c, e16o, e16c, e5o, e5c, sv;
    a8 = 8'hFF; s8 = 4'd1;
    a16 = '0; s16 = '0;
    a5 = '0; s5 = '0;
    #1;
    check("rst_init_out", 32'(o8), 32'h0);
    check("rst_init_cout", 32'(c8), 32'h0);
    repeat (3) begin
      tick();
      check("rst_hold_out", 32'(o8), 32'h0);
      check("rst_hold_cout", 32'(c8), 32'h0);
    end
    #2 rst_n = 1'b1;
    tick();
    check("rst_rel_out", 32'(o8), 32'h7F);
    check("rst_rel_cout", 32'(c8), 32'h1);

    step8("f0_s1", 8'hF0, 4'd1, 8'h78, 1'b0);
    step8("f0_s3", 8'hF0, 4'd3, 8'h1E, 1'b0);
    step8("f0_s6", 8'hF0, 4'd6, 8'h03, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(o8), 32'h0);
    check("arst_cout", 32'(c8), 32'h0);
    #1 rst_n = 1'b1;

    step8("b_s0", 8'h81, 4'd0, 8'h81, 1'b0);
    step8("b_s7", 8'h81, 4'd7, 8'h01, 1'b0);
    step8("b_s8", 8'h81, 4'd8, 8'h00, 1'b1);
    step8("b_s15", 8'h81, 4'd15, 8'h00, 1'b0);

    step8("lat_a", 8'hF0, 4'd3, 8'h1E, 1'b0);
    #2;
    a8 = 8'h81;
    s8 = 4'd0;
    #2;
    check("lat_hold_out", 32'(o8), 32'h1E);
    check("lat_hold_cout", 32'(c8), 32'h0);
    tick();
    check("lat_next_out", 32'(o8), 32'h81);
    check("lat_next_cout", 32'(c8), 32'h0);

    for (int i = 0; i < 400; i++) begin
      sv  = (i < 32) ? i : int'($urandom);
      a8  = 8'($urandom);
      s8  = 4'(sv);
      a16 = 16'($urandom);
      s16 = 5'(sv);
      a5  = 5'($urandom);
      s5  = 4'(sv);
      e8o  = ref_out(8, int'(a8), int'(s8));
      e8c  = ref_c(8, int'(a8), int'(s8));
      e16o = ref_out(16, int'(a16), int'(s16));
      e16c = ref_c(16, int'(a16), int'(s16));
      e5o  = ref_out(5, int'(a5), int'(s5));
      e5c  = ref_c(5, int'(a5), int'(s5));
      tick();
      check("rnd8_out", 32'(o8), 32'(e8o));
      check("rnd8_cout", 32'(c8), 32'(e8c));
      check("rnd16_out", 32'(o16), 32'(e16o));
      check("rnd16_cout", 32'(c16), 32'(e16c));
      check("rnd5_out", 32'(o5), 32'(e5o));
      check("rnd5_cout", 32'(c5), 32'(e5c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
